// File: rtl/cache_snoop_responder_pkg.sv
// Shared cache definitions: address split macros, MESI and snoop FSM encodings.
`ifndef CACHE_DEFS_SV
`define CACHE_DEFS_SV
// Address_Com carries a block address: index in the low bits, tag above it.
`define ADDRESSSIZE   32
`define INDEX_SIZE    6
`define INDEX_LSB     0
`define INDEX_MSB     5
`define TAG_SIZE      26
`define TAG_LSB       6
`define TAG_MSB       31
`define ASSOCIATIVITY 4
`endif

package cache_snoop_responder_pkg;

  localparam int ADDR_W    = `ADDRESSSIZE;
  localparam int INDEX_W   = `INDEX_SIZE;
  localparam int INDEX_LSB = `INDEX_LSB;
  localparam int INDEX_MSB = `INDEX_MSB;
  localparam int TAG_W     = `TAG_SIZE;
  localparam int TAG_LSB   = `TAG_LSB;
  localparam int TAG_MSB   = `TAG_MSB;
  localparam int WAYS      = `ASSOCIATIVITY;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } snoop_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_RDX  = 2'd2,
    OP_UPGR = 2'd3
  } bus_op_t;

  // Result of the next-MESI decode: ok=0 means the op/state pair is illegal.
  typedef struct packed {
    logic  ok;
    mesi_t value;
  } mesi_update_t;

endpackage

// File: rtl/cache_snoop_responder.sv
// Snoop responder: looks up a snooped bus op, flushes dirty data when needed,
// and writes the new MESI state back into the cache block.
module cache_snoop_responder
  import cache_snoop_responder_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               BusRd,
  input  logic               BusRdX,
  input  logic               BusUpgr,
  input  logic [ADDR_W-1:0]  Address_Com,
  output logic [INDEX_W-1:0] Lookup_Index,
  output logic [TAG_W-1:0]   Lookup_Tag,
  input  logic               Snoop_Hit,
  input  logic [WAYS-1:0]    Snoop_Way,
  input  logic [1:0]         Snoop_State,
  input  logic [ADDR_W-1:0]  Blk_Data,
  output logic               State_Wr_En,
  output logic [WAYS-1:0]    State_Wr_Way,
  output logic [1:0]         State_Wr_Value,
  output logic               Shared,
  output logic [ADDR_W-1:0]  Data_Bus_Com_Out,
  output logic               Data_Bus_Com_En,
  input  logic               Flush_Ack,
  output logic               Snoop_Busy,
  output logic               Snoop_Done,
  output logic               Protocol_Err
);

  snoop_state_t       state_q, state_d;
  bus_op_t            op_q, new_op;
  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WAYS-1:0]    way_q;
  mesi_t              mesi_q;
  logic [ADDR_W-1:0]  data_q;
  logic               shared_q;
  logic               err_q;
  logic [1:0]         op_cnt;
  logic               any_op, one_op;
  logic               lookup_shared;
  logic               wr_en, err_set;
  mesi_update_t       upd;

  // New MESI state for a snooped op hitting a line in state cur.
  function automatic mesi_update_t next_mesi(bus_op_t op, mesi_t cur);
    mesi_update_t r;
    r.ok    = 1'b0;
    r.value = MESI_I;
    case (op)
      OP_RD:   if (cur != MESI_I) begin r.ok = 1'b1; r.value = MESI_S; end
      OP_RDX:  if (cur != MESI_I) begin r.ok = 1'b1; r.value = MESI_I; end
      OP_UPGR: if (cur == MESI_S) begin r.ok = 1'b1; r.value = MESI_I; end
      default: ;
    endcase
    return r;
  endfunction

  // Classify the incoming bus op bits.
  always_comb begin
    op_cnt = {1'b0, BusRd} + {1'b0, BusRdX} + {1'b0, BusUpgr};
    any_op = BusRd | BusRdX | BusUpgr;
    one_op = (op_cnt == 2'd1);
    new_op = BusRd ? OP_RD : (BusRdX ? OP_RDX : (BusUpgr ? OP_UPGR : OP_NONE));
    lookup_shared = (op_q == OP_RD) && Snoop_Hit && (mesi_t'(Snoop_State) != MESI_I);
  end

  // Next-state and control decode.
  // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    err_set = 1'b0;
    upd     = next_mesi(op_q, mesi_q);
    case (state_q)
      ST_IDLE: begin
        if (any_op) begin
          if (one_op) state_d = ST_LOOKUP;
          else        err_set = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (!Snoop_Hit || mesi_t'(Snoop_State) == MESI_I)
          state_d = ST_DONE;
        else if (mesi_t'(Snoop_State) == MESI_M && (op_q == OP_RD || op_q == OP_RDX))
          state_d = ST_FLUSH;
        else
          state_d = ST_UPDATE;
      end
      ST_FLUSH: begin
        if (Flush_Ack) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (upd.ok) wr_en   = 1'b1;
        else        err_set = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && any_op) err_set = 1'b1;
  end

  // State register plus op, address and lookup-result capture.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      index_q  <= '0;
      tag_q    <= '0;
      way_q    <= '0;
      mesi_q   <= MESI_I;
      data_q   <= '0;
      shared_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && one_op) begin
        op_q    <= new_op;
        index_q <= Address_Com[INDEX_MSB:INDEX_LSB];
        tag_q   <= Address_Com[TAG_MSB:TAG_LSB];
      end
      if (state_q == ST_LOOKUP) begin
        way_q    <= Snoop_Way;
        mesi_q   <= mesi_t'(Snoop_State);
        data_q   <= Blk_Data;
        shared_q <= lookup_shared;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  // Moore-style outputs decoded from the state register, so reset clears them at once.
  always_comb begin
    Lookup_Index     = index_q;
    Lookup_Tag       = tag_q;
    Snoop_Busy       = (state_q != ST_IDLE);
    Snoop_Done       = (state_q == ST_DONE);
    Data_Bus_Com_En  = (state_q == ST_FLUSH);
    Data_Bus_Com_Out = (state_q == ST_FLUSH) ? data_q : '0;
    State_Wr_En      = wr_en;
    State_Wr_Way     = wr_en ? way_q : '0;
    State_Wr_Value   = wr_en ? upd.value : MESI_I;
    Protocol_Err     = err_q;
    case (state_q)
      ST_LOOKUP:                     Shared = lookup_shared;
      ST_FLUSH, ST_UPDATE, ST_DONE:  Shared = shared_q;
      default:                       Shared = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_snoop_responder.sv
// Directed bench for cache_snoop_responder. The op cycle counts as cycle 1.
module tb_cache_snoop_responder;
  import cache_snoop_responder_pkg::*;

  logic               CLK = 1'b0;
  logic               RST;
  logic               BusRd, BusRdX, BusUpgr;
  logic [ADDR_W-1:0]  Address_Com;
  logic [INDEX_W-1:0] Lookup_Index;
  logic [TAG_W-1:0]   Lookup_Tag;
  logic               Snoop_Hit;
  logic [WAYS-1:0]    Snoop_Way;
  logic [1:0]         Snoop_State;
  logic [ADDR_W-1:0]  Blk_Data;
  logic               State_Wr_En;
  logic [WAYS-1:0]    State_Wr_Way;
  logic [1:0]         State_Wr_Value;
  logic               Shared;
  logic [ADDR_W-1:0]  Data_Bus_Com_Out;
  logic               Data_Bus_Com_En;
  logic               Flush_Ack;
  logic               Snoop_Busy, Snoop_Done, Protocol_Err;

  int n_checks = 0;
  int n_fail   = 0;

  cache_snoop_responder dut (
    .CLK(CLK), .RST(RST),
    .BusRd(BusRd), .BusRdX(BusRdX), .BusUpgr(BusUpgr),
    .Address_Com(Address_Com),
    .Lookup_Index(Lookup_Index), .Lookup_Tag(Lookup_Tag),
    .Snoop_Hit(Snoop_Hit), .Snoop_Way(Snoop_Way), .Snoop_State(Snoop_State),
    .Blk_Data(Blk_Data),
    .State_Wr_En(State_Wr_En), .State_Wr_Way(State_Wr_Way), .State_Wr_Value(State_Wr_Value),
    .Shared(Shared),
    .Data_Bus_Com_Out(Data_Bus_Com_Out), .Data_Bus_Com_En(Data_Bus_Com_En),
    .Flush_Ack(Flush_Ack),
    .Snoop_Busy(Snoop_Busy), .Snoop_Done(Snoop_Done), .Protocol_Err(Protocol_Err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    BusRd = 0; BusRdX = 0; BusUpgr = 0; Address_Com = '0;
    Snoop_Hit = 0; Snoop_Way = '0; Snoop_State = 2'b00; Blk_Data = '0; Flush_Ack = 0;
  endtask

  task automatic lookup(input logic hit, input logic [WAYS-1:0] way, input logic [1:0] st,
                        input logic [31:0] data);
    Snoop_Hit = hit; Snoop_Way = way; Snoop_State = st; Blk_Data = data;
  endtask

  task automatic pulse_reset();
    RST = 1; settle();
    tick();
    RST = 0;
  endtask

  initial begin
    RST = 1;
    quiet_inputs();

    // ---------- reset state ----------
    tick(); tick(); settle();
    check("rst_busy",   32'(Snoop_Busy), 32'h0);
    check("rst_done",   32'(Snoop_Done), 32'h0);
    check("rst_err",    32'(Protocol_Err), 32'h0);
    check("rst_wr_en",  32'(State_Wr_En), 32'h0);
    check("rst_bus_en", 32'(Data_Bus_Com_En), 32'h0);
    check("rst_shared", 32'(Shared), 32'h0);
    check("rst_index",  32'(Lookup_Index), 32'h0);
    RST = 0;

    // ---------- BusRd hit way 2 in E: Shared, write S, done at cycle 4 ----------
    tick(); BusRd = 1; Address_Com = 32'h1234_5678; settle();          // cycle 1
    check("rd_e_c1_busy", 32'(Snoop_Busy), 32'h0);
    tick(); quiet_inputs(); lookup(1, 4'b0100, 2'b10, 32'h0BAD_0000); settle();   // cycle 2
    check("rd_e_index",  32'(Lookup_Index), 32'h38);
    check("rd_e_tag",    32'(Lookup_Tag), 32'h48_D159);
    check("rd_e_busy",   32'(Snoop_Busy), 32'h1);
    check("rd_e_shared_lookup", 32'(Shared), 32'h1);
    check("rd_e_done_c2", 32'(Snoop_Done), 32'h0);
    tick(); quiet_inputs(); settle();                                  // cycle 3
    check("rd_e_wr_en",  32'(State_Wr_En), 32'h1);
    check("rd_e_wr_way", 32'(State_Wr_Way), 32'h4);
    check("rd_e_wr_val", 32'(State_Wr_Value), 32'h1);
    check("rd_e_shared_upd", 32'(Shared), 32'h1);
    check("rd_e_bus_en", 32'(Data_Bus_Com_En), 32'h0);
    tick(); settle();                                                  // cycle 4
    check("rd_e_done",   32'(Snoop_Done), 32'h1);
    check("rd_e_shared_done", 32'(Shared), 32'h1);
    check("rd_e_wr_en_done", 32'(State_Wr_En), 32'h0);
    tick(); settle();                                                  // cycle 5
    check("rd_e_done_off", 32'(Snoop_Done), 32'h0);
    check("rd_e_idle",   32'(Snoop_Busy), 32'h0);
    check("rd_e_shared_off", 32'(Shared), 32'h0);

    // ---------- BusRd hit M, Flush_Ack in first FLUSH cycle: flush then write S ----------
    tick(); BusRd = 1; Address_Com = 32'h0000_0083; settle();         // cycle 1
    tick(); quiet_inputs(); lookup(1, 4'b0001, 2'b11, 32'hDEAD_BEEF); settle();  // cycle 2
    check("rd_m_shared_lookup", 32'(Shared), 32'h1);
    check("rd_m_index", 32'(Lookup_Index), 32'h03);
    check("rd_m_tag",   32'(Lookup_Tag), 32'h2);
    tick(); quiet_inputs(); Flush_Ack = 1; settle();                   // cycle 3
    check("rd_m_bus_en",  32'(Data_Bus_Com_En), 32'h1);
    check("rd_m_bus_out", Data_Bus_Com_Out, 32'hDEAD_BEEF);
    check("rd_m_shared_flush", 32'(Shared), 32'h1);
    tick(); Flush_Ack = 0; settle();                                   // cycle 4
    check("rd_m_bus_released", 32'(Data_Bus_Com_En), 32'h0);
    check("rd_m_wr_en",  32'(State_Wr_En), 32'h1);
    check("rd_m_wr_way", 32'(State_Wr_Way), 32'h1);
    check("rd_m_wr_val", 32'(State_Wr_Value), 32'h1);
    tick(); settle();                                                  // cycle 5
    check("rd_m_done", 32'(Snoop_Done), 32'h1);

    // ---------- BusRdX hit way 1 in M, ack after 3 cycles: 3 flush cycles, write I ----------
    tick(); BusRdX = 1; Address_Com = 32'h0000_0041; settle();        // cycle 1
    check("rdx_busy_c1", 32'(Snoop_Busy), 32'h0);
    tick(); quiet_inputs(); lookup(1, 4'b0010, 2'b11, 32'hA5A5_0001); settle();  // cycle 2
    check("rdx_shared_lookup", 32'(Shared), 32'h0);
    check("rdx_bus_en_lookup", 32'(Data_Bus_Com_En), 32'h0);
    for (int k = 0; k < 3; k++) begin                                 // cycles 3..5
      tick(); quiet_inputs(); Flush_Ack = (k == 2); settle();
      check($sformatf("rdx_flush%0d_en", k),  32'(Data_Bus_Com_En), 32'h1);
      check($sformatf("rdx_flush%0d_out", k), Data_Bus_Com_Out, 32'hA5A5_0001);
      check($sformatf("rdx_flush%0d_wr", k),  32'(State_Wr_En), 32'h0);
    end
    tick(); Flush_Ack = 0; settle();                                   // cycle 6
    check("rdx_bus_released", 32'(Data_Bus_Com_En), 32'h0);
    check("rdx_bus_out_zero", Data_Bus_Com_Out, 32'h0);
    check("rdx_wr_en",  32'(State_Wr_En), 32'h1);
    check("rdx_wr_way", 32'(State_Wr_Way), 32'h2);
    check("rdx_wr_val", 32'(State_Wr_Value), 32'h0);
    tick(); settle();                                                  // cycle 7
    check("rdx_done", 32'(Snoop_Done), 32'h1);
    tick(); settle();
    check("rdx_idle", 32'(Snoop_Busy), 32'h0);

    // ---------- BusUpgr hit S way 3: write I, no Shared ----------
    tick(); BusUpgr = 1; Address_Com = 32'hFFFF_FFC7; settle();
    tick(); quiet_inputs(); lookup(1, 4'b1000, 2'b01, 32'h0); settle();
    check("upgr_s_shared", 32'(Shared), 32'h0);
    check("upgr_s_index",  32'(Lookup_Index), 32'h07);
    check("upgr_s_tag",    32'(Lookup_Tag), 32'h3FF_FFFF);
    tick(); quiet_inputs(); settle();
    check("upgr_s_wr_en",  32'(State_Wr_En), 32'h1);
    check("upgr_s_wr_way", 32'(State_Wr_Way), 32'h8);
    check("upgr_s_wr_val", 32'(State_Wr_Value), 32'h0);
    tick(); settle();
    check("upgr_s_done", 32'(Snoop_Done), 32'h1);
    check("upgr_s_err",  32'(Protocol_Err), 32'h0);

    // ---------- BusRd miss: no write, no Shared, done at cycle 3 ----------
    tick(); BusRd = 1; Address_Com = 32'h0000_1000; settle();
    tick(); quiet_inputs(); lookup(0, 4'b0001, 2'b10, 32'h0); settle();
    check("miss_shared", 32'(Shared), 32'h0);
    check("miss_wr_en_c2", 32'(State_Wr_En), 32'h0);
    check("miss_done_c2", 32'(Snoop_Done), 32'h0);
    tick(); quiet_inputs(); settle();
    check("miss_done", 32'(Snoop_Done), 32'h1);
    check("miss_wr_en", 32'(State_Wr_En), 32'h0);
    tick(); settle();
    check("miss_idle", 32'(Snoop_Busy), 32'h0);

    // ---------- hit on an I line behaves as a miss ----------
    tick(); BusRdX = 1; Address_Com = 32'h0000_0010; settle();
    tick(); quiet_inputs(); lookup(1, 4'b0100, 2'b00, 32'h0); settle();
    tick(); quiet_inputs(); settle();
    check("inv_done", 32'(Snoop_Done), 32'h1);
    check("inv_wr_en", 32'(State_Wr_En), 32'h0);

    // ---------- RST mid-FLUSH: outputs drop immediately, next op normal ----------
    tick(); BusRdX = 1; Address_Com = 32'h0000_0022; settle();
    tick(); quiet_inputs(); lookup(1, 4'b0100, 2'b11, 32'h1111_2222); settle();
    tick(); quiet_inputs(); settle();
    check("rstf_bus_en_before", 32'(Data_Bus_Com_En), 32'h1);
    #2; RST = 1; settle();
    check("rstf_bus_en", 32'(Data_Bus_Com_En), 32'h0);
    check("rstf_bus_out", Data_Bus_Com_Out, 32'h0);
    check("rstf_busy", 32'(Snoop_Busy), 32'h0);
    check("rstf_wr_en", 32'(State_Wr_En), 32'h0);
    check("rstf_index", 32'(Lookup_Index), 32'h0);
    Flush_Ack = 1;
    tick(); settle();
    check("rstf_wr_en_held", 32'(State_Wr_En), 32'h0);
    RST = 0; Flush_Ack = 0;
    tick(); BusRd = 1; Address_Com = 32'h0000_0009; settle();
    tick(); quiet_inputs(); lookup(0, 4'b0000, 2'b00, 32'h0); settle();
    check("rstf_next_index", 32'(Lookup_Index), 32'h09);
    tick(); settle();
    check("rstf_next_done", 32'(Snoop_Done), 32'h1);
    check("rstf_next_err", 32'(Protocol_Err), 32'h0);

    // ---------- op while busy: ignored, error set, snoop completes unchanged ----------
    tick(); BusRd = 1; Address_Com = 32'h0000_0005; settle();
    tick(); quiet_inputs(); lookup(1, 4'b0001, 2'b10, 32'h0); BusRdX = 1; settle();
    check("busy_op_shared", 32'(Shared), 32'h1);
    tick(); quiet_inputs(); settle();
    check("busy_op_err", 32'(Protocol_Err), 32'h1);
    check("busy_op_wr_en", 32'(State_Wr_En), 32'h1);
    check("busy_op_wr_way", 32'(State_Wr_Way), 32'h1);
    check("busy_op_wr_val", 32'(State_Wr_Value), 32'h1);
    tick(); settle();
    check("busy_op_done", 32'(Snoop_Done), 32'h1);
    tick(); settle();
    check("busy_op_idle", 32'(Snoop_Busy), 32'h0);
    check("busy_op_err_sticky", 32'(Protocol_Err), 32'h1);

    // ---------- BusRd and BusRdX together: error, stay idle ----------
    pulse_reset(); settle();
    check("dual_err_cleared", 32'(Protocol_Err), 32'h0);
    tick(); BusRd = 1; BusRdX = 1; Address_Com = 32'h0000_0033; settle();
    tick(); quiet_inputs(); settle();
    check("dual_err", 32'(Protocol_Err), 32'h1);
    check("dual_busy", 32'(Snoop_Busy), 32'h0);
    check("dual_index", 32'(Lookup_Index), 32'h0);
    tick(); settle();
    check("dual_busy_c3", 32'(Snoop_Busy), 32'h0);
    check("dual_wr_en", 32'(State_Wr_En), 32'h0);

    // ---------- BusUpgr hitting M: error, no write ----------
    pulse_reset();
    tick(); BusUpgr = 1; Address_Com = 32'h0000_0044; settle();
    tick(); quiet_inputs(); lookup(1, 4'b0010, 2'b11, 32'h5555_AAAA); settle();
    check("upgr_m_bus_en_lookup", 32'(Data_Bus_Com_En), 32'h0);
    tick(); quiet_inputs(); settle();
    check("upgr_m_wr_en", 32'(State_Wr_En), 32'h0);
    check("upgr_m_bus_en", 32'(Data_Bus_Com_En), 32'h0);
    check("upgr_m_err_pre", 32'(Protocol_Err), 32'h0);
    tick(); settle();
    check("upgr_m_err", 32'(Protocol_Err), 32'h1);
    check("upgr_m_done", 32'(Snoop_Done), 32'h1);
    tick(); settle();
    check("upgr_m_err_sticky", 32'(Protocol_Err), 32'h1);
    check("upgr_m_idle", 32'(Snoop_Busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
